// File: rtl/cpu_run_ctrl_pkg.sv
// rtl/cpu_run_ctrl_pkg.sv - shared state encodings and cause bit indices for the run controller
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_EXC  = 2'd3
    } run_state_t;

    localparam int CAUSE_OVF  = 2;
    localparam int CAUSE_ADDR = 1;
    localparam int CAUSE_DIVZ = 0;

endpackage

// File: rtl/cpu_run_ctrl_edge_rise.sv
// rtl/cpu_run_ctrl_edge_rise.sv - registered rising-edge detector with parameterised history reset value
module edge_rise #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic SYS_clk,
    input  logic SYS_rst,
    input  logic level,
    output logic rise
);

    logic prev_q;

    // History resets to RST_VAL so an input held through reset is not seen as an edge.
    always_ff @(posedge SYS_clk) begin
        if (!SYS_rst) begin
            prev_q <= RST_VAL;
            rise   <= 1'b0;
        end else begin
            prev_q <= level;
            rise   <= level & ~prev_q;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - PC owner and run/step/halt sequencer for the single-cycle datapath
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int           EXC_MODE   = 0,
    parameter logic [7:0]   EXC_VECTOR = 8'hF0,
    parameter int           RET_W      = 16
) (
    input  logic             SYS_clk,
    input  logic             SYS_rst,
    input  logic             SYS_load,
    input  logic [7:0]       SYS_pc_val,
    input  logic             run_en,
    input  logic             step_btn,
    input  logic             resume,
    input  logic [7:0]       pc_next,
    input  logic             eh_flag,
    input  logic [2:0]       eh_cause,
    output logic [7:0]       pc_current,
    output logic             commit,
    output logic [7:0]       epc,
    output logic [2:0]       cause,
    output logic             halted,
    output logic [1:0]       state,
    output logic [RET_W-1:0] retired
);

    logic load_rise;
    logic step_rise;
    logic resume_rise;

    edge_rise #(.RST_VAL(1'b1)) u_load_edge (
        .SYS_clk (SYS_clk),
        .SYS_rst (SYS_rst),
        .level   (SYS_load),
        .rise    (load_rise)
    );

    edge_rise #(.RST_VAL(1'b1)) u_step_edge (
        .SYS_clk (SYS_clk),
        .SYS_rst (SYS_rst),
        .level   (step_btn),
        .rise    (step_rise)
    );

    edge_rise #(.RST_VAL(1'b1)) u_resume_edge (
        .SYS_clk (SYS_clk),
        .SYS_rst (SYS_rst),
        .level   (resume),
        .rise    (resume_rise)
    );

    run_state_t       state_q, state_d;
    logic [7:0]       pc_d, epc_d;
    logic [2:0]       cause_d;
    logic [RET_W-1:0] ret_d;
    logic             commit_c;
    logic             exc_take;

    always_ff @(posedge SYS_clk) begin
        if (!SYS_rst) begin
            state_q    <= ST_IDLE;
            pc_current <= 8'h00;
            epc        <= 8'h00;
            cause      <= 3'b000;
            retired    <= '0;
        end else begin
            state_q    <= state_d;
            pc_current <= pc_d;
            epc        <= epc_d;
            cause      <= cause_d;
            retired    <= ret_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_current;
        epc_d    = epc;
        cause_d  = cause;
        ret_d    = retired;
        commit_c = 1'b0;
        exc_take = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_rise)      pc_d    = SYS_pc_val;
                else if (step_rise) state_d = ST_STEP;
                else if (run_en)    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (eh_flag)     exc_take = 1'b1;
                else if (run_en) commit_c = 1'b1;
                else             state_d  = ST_IDLE;
            end
            ST_STEP: begin
                state_d = ST_IDLE;
                if (eh_flag) exc_take = 1'b1;
                else         commit_c = 1'b1;
            end
            ST_EXC: begin
                if (load_rise) begin
                    pc_d    = SYS_pc_val;
                    state_d = ST_IDLE;
                end else if (resume_rise) begin
                    pc_d    = epc + 8'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit_c) begin
            pc_d  = pc_next;
            ret_d = retired + 1'b1;
        end

        // The faulting instruction never retires; in halt mode its PC stays put for inspection.
        if (exc_take) begin
            epc_d   = pc_current;
            cause_d = eh_cause;
            if (EXC_MODE == 0) begin
                state_d = ST_EXC;
            end else begin
                pc_d    = EXC_VECTOR;
                state_d = (state_q == ST_STEP) ? ST_IDLE : ST_RUN;
            end
        end
    end

    // Gated by reset so the instruction in flight cannot write on the resetting edge.
    assign commit = commit_c & SYS_rst;
    assign halted = (state_q == ST_EXC);
    assign state  = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench: halt-mode and vector-mode controllers against a reference model
module tb_cpu_run_ctrl;

    logic       SYS_clk = 1'b0;
    logic       SYS_rst;
    logic       SYS_load;
    logic [7:0] SYS_pc_val;
    logic       run_en;
    logic       step_btn;
    logic       resume;
    logic [7:0] pc_next [2];
    logic       eh_flag;
    logic [2:0] eh_cause;

    logic [7:0]  pc_current0, epc0, pc_current1, epc1;
    logic        commit0, halted0, commit1, halted1;
    logic [2:0]  cause0, cause1;
    logic [1:0]  state0, state1;
    logic [15:0] retired0;
    logic [3:0]  retired1;

    int checks = 0;
    int errors = 0;

    always #5 SYS_clk = ~SYS_clk;

    cpu_run_ctrl #(.EXC_MODE(0), .EXC_VECTOR(8'hF0), .RET_W(16)) dut0 (
        .SYS_clk(SYS_clk), .SYS_rst(SYS_rst), .SYS_load(SYS_load), .SYS_pc_val(SYS_pc_val),
        .run_en(run_en), .step_btn(step_btn), .resume(resume), .pc_next(pc_next[0]),
        .eh_flag(eh_flag), .eh_cause(eh_cause), .pc_current(pc_current0), .commit(commit0),
        .epc(epc0), .cause(cause0), .halted(halted0), .state(state0), .retired(retired0)
    );

    cpu_run_ctrl #(.EXC_MODE(1), .EXC_VECTOR(8'hF0), .RET_W(4)) dut1 (
        .SYS_clk(SYS_clk), .SYS_rst(SYS_rst), .SYS_load(SYS_load), .SYS_pc_val(SYS_pc_val),
        .run_en(run_en), .step_btn(step_btn), .resume(resume), .pc_next(pc_next[1]),
        .eh_flag(eh_flag), .eh_cause(eh_cause), .pc_current(pc_current1), .commit(commit1),
        .epc(epc1), .cause(cause1), .halted(halted1), .state(state1), .retired(retired1)
    );

    // Reference model: states 0 idle, 1 run, 2 step, 3 halted on exception.
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_EXC = 3;
    int         m_st   [2];
    logic [7:0] m_pc   [2];
    logic [7:0] m_epc  [2];
    logic [2:0] m_cause[2];
    int         m_ret  [2];
    int         m_mod  [2] = '{65536, 16};
    int         m_mode [2] = '{0, 1};
    bit prev_load, prev_step, prev_res;
    bit pend_load, pend_step, pend_res;

    function automatic bit exp_commit(int i);
        if (!SYS_rst) return 1'b0;
        if (m_st[i] == M_RUN)  return run_en && !eh_flag;
        if (m_st[i] == M_STEP) return !eh_flag;
        return 1'b0;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!SYS_rst) begin
                m_st[i] = M_IDLE; m_pc[i] = 0; m_epc[i] = 0; m_cause[i] = 0; m_ret[i] = 0;
            end else if (m_st[i] == M_IDLE) begin
                if (pend_load)      m_pc[i] = SYS_pc_val;
                else if (pend_step) m_st[i] = M_STEP;
                else if (run_en)    m_st[i] = M_RUN;
            end else if (m_st[i] == M_EXC) begin
                if (pend_load)     begin m_pc[i] = SYS_pc_val;       m_st[i] = M_IDLE; end
                else if (pend_res) begin m_pc[i] = m_epc[i] + 8'd1;  m_st[i] = M_IDLE; end
            end else if (eh_flag) begin
                m_epc[i] = m_pc[i];
                m_cause[i] = eh_cause;
                if (m_mode[i] == 0) m_st[i] = M_EXC;
                else begin
                    m_pc[i] = 8'hF0;
                    if (m_st[i] == M_STEP) m_st[i] = M_IDLE;
                end
            end else if (m_st[i] == M_STEP || run_en) begin
                m_pc[i] = pc_next[i];
                m_ret[i] = (m_ret[i] + 1) % m_mod[i];
                if (m_st[i] == M_STEP) m_st[i] = M_IDLE;
            end else begin
                m_st[i] = M_IDLE;
            end
        end
        if (!SYS_rst) begin
            prev_load = 1; prev_step = 1; prev_res = 1;
            pend_load = 0; pend_step = 0; pend_res = 0;
        end else begin
            pend_load = SYS_load && !prev_load; prev_load = SYS_load;
            pend_step = step_btn && !prev_step; prev_step = step_btn;
            pend_res  = resume && !prev_res;    prev_res  = resume;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check commit before the edge, advance the model, check registers after.
    task automatic cycle();
        bit c0, c1;
        #1;
        c0 = exp_commit(0);
        c1 = exp_commit(1);
        chk("commit0", 32'(commit0), 32'(c0));
        chk("commit1", 32'(commit1), 32'(c1));
        @(posedge SYS_clk);
        model_edge();
        #1;
        chk("pc0",      32'(pc_current0), 32'(m_pc[0]));
        chk("epc0",     32'(epc0),        32'(m_epc[0]));
        chk("cause0",   32'(cause0),      32'(m_cause[0]));
        chk("retired0", 32'(retired0),    32'(m_ret[0]));
        chk("state0",   32'(state0),      32'(m_st[0]));
        chk("halted0",  32'(halted0),     32'(m_st[0] == M_EXC));
        chk("pc1",      32'(pc_current1), 32'(m_pc[1]));
        chk("epc1",     32'(epc1),        32'(m_epc[1]));
        chk("cause1",   32'(cause1),      32'(m_cause[1]));
        chk("retired1", 32'(retired1),    32'(m_ret[1]));
        chk("state1",   32'(state1),      32'(m_st[1]));
        chk("halted1",  32'(halted1),     32'(m_st[1] == M_EXC));
    endtask

    task automatic seq_next();
        pc_next[0] = m_pc[0] + 8'd1;
        pc_next[1] = m_pc[1] + 8'd1;
    endtask

    task automatic pulse_load(input logic [7:0] v);
        SYS_pc_val = v;
        SYS_load = 1; cycle();
        SYS_load = 0; cycle();
    endtask

    initial begin
        SYS_rst = 0; SYS_load = 0; SYS_pc_val = 0; run_en = 0; step_btn = 0; resume = 0;
        pc_next[0] = 0; pc_next[1] = 0; eh_flag = 0; eh_cause = 0;
        prev_load = 1; prev_step = 1; prev_res = 1; pend_load = 0; pend_step = 0; pend_res = 0;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = M_IDLE; m_pc[i] = 0; m_epc[i] = 0; m_cause[i] = 0; m_ret[i] = 0;
        end
        @(negedge SYS_clk);
        cycle(); cycle();
        chk("reset_pc",    32'(pc_current0), 32'h00);
        chk("reset_state", 32'(state0),      32'd0);
        SYS_rst = 1;

        // Free run five instructions from PC 0
        run_en = 1; seq_next(); cycle();
        for (int k = 0; k < 5; k++) begin seq_next(); cycle(); end
        chk("run5_pc",      32'(pc_current0), 32'h05);
        chk("run5_retired", 32'(retired0),    32'd5);
        run_en = 0; cycle();

        // Load then single step
        pulse_load(8'h3C);
        chk("load_pc", 32'(pc_current0), 32'h3C);
        step_btn = 1; pc_next[0] = 8'h77; pc_next[1] = 8'h77;
        cycle(); cycle(); cycle();
        chk("step_pc",    32'(pc_current0), 32'h77);
        chk("step_state", 32'(state0),      32'd0);
        step_btn = 0; cycle(); cycle();

        // Exception at PC 07
        pulse_load(8'h07);
        run_en = 1; seq_next(); cycle();
        eh_flag = 1; eh_cause = 3'b100; cycle();
        chk("exc_epc",     32'(epc0),        32'h07);
        chk("exc_halted",  32'(halted0),     32'd1);
        chk("exc_pc",      32'(pc_current0), 32'h07);
        chk("vec_pc",      32'(pc_current1), 32'hF0);
        chk("vec_state",   32'(state1),      32'd1);
        eh_flag = 0; run_en = 0; cycle();
        resume = 1; cycle(); cycle();
        chk("resume_pc",    32'(pc_current0), 32'h08);
        chk("resume_state", 32'(state0),      32'd0);
        resume = 0; cycle();

        // PC wrap and narrow retired-counter wrap
        pulse_load(8'hFF);
        run_en = 1; seq_next(); cycle();
        seq_next(); cycle();
        chk("wrap_pc", 32'(pc_current0), 32'h00);
        for (int k = 0; k < 20; k++) begin seq_next(); cycle(); end

        // Mid-run reset, then step held through reset release
        SYS_rst = 0; cycle();
        chk("midrst_pc",  32'(pc_current0), 32'h00);
        chk("midrst_ret", 32'(retired0),    32'd0);
        run_en = 0; step_btn = 1; cycle();
        SYS_rst = 1; cycle(); cycle(); cycle();
        chk("held_step_state", 32'(state0), 32'd0);
        step_btn = 0; cycle();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            SYS_rst    = ($urandom_range(0, 99) != 0);
            run_en     = ($urandom_range(0, 3) != 0);
            SYS_load   = ($urandom_range(0, 5) == 0);
            step_btn   = ($urandom_range(0, 4) == 0);
            resume     = ($urandom_range(0, 4) == 0);
            eh_flag    = ($urandom_range(0, 7) == 0);
            eh_cause   = 3'($urandom);
            SYS_pc_val = 8'($urandom);
            pc_next[0] = 8'($urandom);
            pc_next[1] = 8'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/halt sequencer for the single-cycle MIPS datapath. It owns the program counter register, loads it from the board switches, free-runs or single-steps the datapath, and stops on exceptions. On an exception it captures EPC and the cause, and it counts retired instructions. It replaces the bare PC flop in `system`. Its `commit` output gates Reg_Write and Mem_Write, so no architectural state changes unless the controller allows it.

## Interface
Parameters:
- `EXC_MODE`, 0. 0 = halt on exception; 1 = vector to `EXC_VECTOR` and keep running.
- `EXC_VECTOR`, 8'hF0. PC loaded on exception when `EXC_MODE`=1.
- `RET_W`, 16. Width of the retired-instruction counter.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - `SYS_clk`  in  1  system clock, sole clock.
  - `SYS_rst`  in  1  synchronous, active-low reset.
- Control inputs (all synchronous levels, already debounced):
  - `SYS_load`  in  1  a rising edge loads `SYS_pc_val` into the PC.
  - `SYS_pc_val`  in  8  switch value for the PC load.
  - `run_en`  in  1  level; 1 = free-run.
  - `step_btn`  in  1  a rising edge executes exactly one instruction.
  - `resume`  in  1  a rising edge leaves the exception halt.
- Datapath inputs:
  - `pc_next`  in  8  next PC computed by the datapath (PC+1, branch or jump).
  - `eh_flag`  in  1  exception raised by the current instruction.
  - `eh_cause`  in  3  {overflow, invalid_addr, div_zero}.
- Outputs:
  - `pc_current`  out  8  PC driving IMEM.
  - `commit`  out  1  the current instruction may write the register file or DMEM.
  - `epc`  out  8  PC of the faulting instruction.
  - `cause`  out  3  latched `eh_cause`.
  - `halted`  out  1  FSM in EXC.
  - `state`  out  2  FSM state, for LEDR/LCD debug.
  - `retired`  out  `RET_W`  count of committed instructions.

## Operation
Edge detection:
- The block rising-edge-detects `SYS_load`, `step_btn` and `resume` internally.
- Each previous-value flop resets to 1, so a button held through reset produces no edge.

FSM states are IDLE, RUN, STEP and EXC.

IDLE (the reset state):
- `commit`=0 and the PC holds.
- Priority: load edge first (`pc_current`<=`SYS_pc_val`, stay IDLE), then step edge (-> STEP), then `run_en`=1 (-> RUN).

RUN:
- `commit` = `run_en` & !`eh_flag`.
- Each edge with `commit`=1: `pc_current`<=`pc_next` and `retired`++.
- `run_en`=0: go to IDLE; no instruction executes on that edge.
- `eh_flag`=1 overrides `run_en`=0.

STEP:
- Lasts exactly one cycle.
- `commit` = !`eh_flag`; on commit the PC advances and `retired`++; next state is IDLE.

Exception (RUN or STEP with `eh_flag`=1):
- `commit`=0: the faulting instruction writes nothing and does not retire.
- `epc`<=`pc_current` and `cause`<=`eh_cause`.
- `EXC_MODE`=0: go to EXC with the PC held at the faulting instruction.
- `EXC_MODE`=1: `pc_current`<=`EXC_VECTOR`; stay in RUN, or go to IDLE if the exception came from STEP.

EXC:
- `commit`=0 and `halted`=1.
- Load edge: PC<=`SYS_pc_val` and go to IDLE.
- Otherwise, resume edge: PC<=`epc`+1 (mod 256, skipping the faulting instruction) and go to IDLE.
- `epc` and `cause` hold until the next exception.

Arithmetic and width rules:
- PC arithmetic is 8-bit and wraps (8'hFF+1 = 8'h00).
- `retired` wraps at 2^`RET_W`.
- `SYS_load` is ignored in RUN and STEP.

## Timing
- Reset (`SYS_rst`=0 at an edge) puts every register at 0: `pc_current`, `epc`, `cause`, `retired`; `state`=IDLE; `halted`=0; `commit`=0.
- Reset mid-run is effective on the first edge; the instruction in flight does not commit.
- `commit` is combinational from the state, `run_en` and `eh_flag`. It is valid in the same cycle as the instruction, before the writing edge.
- Latency from a button edge to its action:
  - Load: PC updates 2 edges after the input rises (1 for the edge detect, 1 for the register).
  - Step: 1 instruction commits at the 3rd edge after `step_btn` rises.
- Simultaneous events in IDLE resolve load > step > run.

## Structure
- Shared include `cpu_ctrl_defs.vh` holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, STEP=2'd2, EXC=2'd3;
  - cause bit indices: OVF=2, ADDR=1, DIVZ=0.
  - `system`'s debug mux also uses this file.
- Sub-module `edge_rise` (flop + AND, reset value parameterised) is instantiated three times.
- Target size: about 150–200 lines of RTL.

## Test plan
- Reset, then `run_en`=1 with `pc_next`=PC+1 for 5 cycles -> `pc_current` 0→5, `retired`=5, `commit`=1 throughout.
- In IDLE, `SYS_pc_val`=8'h3C with a `SYS_load` pulse -> PC=8'h3C two edges later; in the same window a `step_btn` edge -> exactly one commit, PC=`pc_next`, back to IDLE.
- RUN at PC=8'h07 with `eh_flag`=1 and `eh_cause`=3'b100 -> `commit`=0 that cycle; `epc`=8'h07, `cause`=3'b100, `halted`=1, PC held, `retired` unchanged; `resume` edge -> PC=8'h08, state IDLE.
- `EXC_MODE`=1 with an exception at PC=8'h12 -> PC=8'hF0, `epc`=8'h12, state stays RUN, `halted`=0.
- Wrap boundaries: PC=8'hFF in RUN with `pc_next`=8'h00 -> PC 8'h00; `retired` preset to 16'hFFFF plus one commit -> 16'h0000.
- `step_btn` held high through reset release -> no step; assert `SYS_rst`=0 mid-RUN -> all outputs 0 and IDLE at the next edge.
